// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: serialises bytes popped from an upstream FIFO onto an
// 8N1/8N2 UART line. One read_en pulse fetches a byte, the next cycle latches
// the FIFO's registered read data, then start, 8 data bits (LSB first) and
// the stop bit(s) are sent. All outputs come from flops that are loaded with
// the decode of the next state, so they line up with the state register.

module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       empty,
    input  logic [7:0] fifo_data,
    input  logic       tx_en,
    output logic       read_en,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    // Timer is sized for the longest interval it counts (two stop bits).
    localparam int TW = $clog2(2 * CLKS_PER_BIT);

    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] STOP_LAST = TW'(STOP_BITS * CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TIMER_ONE = TW'(1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_LOAD  = 3'd2;
    localparam logic [2:0] ST_START = 3'd3;
    localparam logic [2:0] ST_DATA  = 3'd4;
    localparam logic [2:0] ST_STOP  = 3'd5;

    logic [2:0]    state_r;
    logic [TW-1:0] timer_r;
    logic [2:0]    bit_idx_r;
    logic [7:0]    shift_r;

    logic [2:0]    state_s;
    logic [TW-1:0] timer_s;
    logic [2:0]    bit_idx_s;
    logic [7:0]    shift_s;
    logic          start_ok_s;

    logic          read_en_s;
    logic          tx_s;
    logic          busy_s;
    logic          frame_done_s;

    logic          read_en_r;
    logic          tx_r;
    logic          busy_r;
    logic          frame_done_r;

    // A new frame may only be started when permitted and a byte is waiting.
    assign start_ok_s = tx_en & ~empty;

    // Next-state, bit timer, bit index and shift register update.
    always_comb begin
        state_s   = state_r;
        timer_s   = timer_r;
        bit_idx_s = bit_idx_r;
        shift_s   = shift_r;
        case (state_r)
            ST_IDLE: begin
                timer_s   = {TW{1'b0}};
                bit_idx_s = 3'd0;
                if (start_ok_s) begin
                    state_s = ST_FETCH;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                state_s = ST_LOAD;
            end
            ST_LOAD: begin
                // FIFO read data is valid in the cycle after the pop.
                shift_s = fifo_data;
                timer_s = {TW{1'b0}};
                state_s = ST_START;
            end
            ST_START: begin
                if (timer_r == BIT_LAST) begin
                    timer_s   = {TW{1'b0}};
                    bit_idx_s = 3'd0;
                    state_s   = ST_DATA;
                end else begin
                    timer_s = timer_r + TIMER_ONE;
                end
            end
            ST_DATA: begin
                if (timer_r == BIT_LAST) begin
                    timer_s = {TW{1'b0}};
                    shift_s = {1'b0, shift_r[7:1]};
                    if (bit_idx_r == 3'd7) begin
                        bit_idx_s = 3'd0;
                        state_s   = ST_STOP;
                    end else begin
                        bit_idx_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    timer_s = timer_r + TIMER_ONE;
                end
            end
            ST_STOP: begin
                // Stop bits run as one long interval of STOP_BITS bit times.
                if (timer_r == STOP_LAST) begin
                    timer_s = {TW{1'b0}};
                    if (start_ok_s) begin
                        state_s = ST_FETCH;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    timer_s = timer_r + TIMER_ONE;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                timer_s   = {TW{1'b0}};
                bit_idx_s = 3'd0;
                shift_s   = 8'h00;
            end
        endcase
    end

    // Moore decode of the upcoming state, to be captured into output flops.
    always_comb begin
        read_en_s    = 1'b0;
        tx_s         = 1'b1;
        busy_s       = 1'b1;
        frame_done_s = 1'b0;
        case (state_s)
            ST_IDLE: begin
                busy_s = 1'b0;
            end
            ST_FETCH: begin
                read_en_s = 1'b1;
            end
            ST_LOAD: begin
                tx_s = 1'b1;
            end
            ST_START: begin
                tx_s = 1'b0;
            end
            ST_DATA: begin
                tx_s = shift_s[0];
            end
            ST_STOP: begin
                frame_done_s = (timer_s == STOP_LAST);
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset abandons any frame in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            timer_r   <= {TW{1'b0}};
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
        end else begin
            state_r   <= state_s;
            timer_r   <= timer_s;
            bit_idx_r <= bit_idx_s;
            shift_r   <= shift_s;
        end
    end

    // Output flops; reset drives the line idle-high immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            read_en_r    <= 1'b0;
            tx_r         <= 1'b1;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            read_en_r    <= read_en_s;
            tx_r         <= tx_s;
            busy_r       <= busy_s;
            frame_done_r <= frame_done_s;
        end
    end

    assign read_en    = read_en_r;
    assign tx         = tx_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;

endmodule
